wb_write_arbiter: RTL

- Shares the single register-file write port between two requesters: the pipeline writeback stage and a long-latency unit (LLU, e.g. a multicycle mul/div).
- The WB stage has priority. LLU results are buffered in a small FIFO and drained in idle WB slots.
- An anti-starvation FSM stalls WB to force a drain.
- Sits between stage_wb outputs and the register file write inputs.

---
 rtl/wb_write_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Shares the register-file write port between the writeback stage (priority)
//   and a long-latency unit whose results queue in a small FIFO. Queued results
//   drain in idle WB slots; if WB keeps the FIFO blocked for MAX_WAIT cycles, a
//   forced drain stalls WB for up to DRAIN_MAX pops.
//
//   state   | meaning
//   S_NORM  | WB has priority, FIFO drains only in idle WB slots
//   S_DRAIN | WB stalled, FIFO head written every cycle
//
// Ports
//   clk, rst             clock, async active-low reset
//   i_wb_*               WB write request (held upstream while o_wb_stall)
//   o_wb_stall           forced-drain stall to the WB stage
//   i_lu_*, o_lu_ready   LLU result push interface
//   o_rf_*               registered register-file write port
//   o_pend_mask          registers with a result still queued or in flight
//   o_fifo_cnt           FIFO occupancy
module wb_write_arbiter #(
  parameter int DEPTH     = 2,
  parameter int MAX_WAIT  = 4,
  parameter int DRAIN_MAX = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wb_we,
  input  logic [4:0]              i_wb_rdst,
  input  logic [31:0]             i_wb_data,
  output logic                    o_wb_stall,
  input  logic                    i_lu_valid,
  input  logic [4:0]              i_lu_rdst,
  input  logic [31:0]             i_lu_data,
  output logic                    o_lu_ready,
  output logic                    o_rf_we,
  output logic [4:0]              o_rf_addr,
  output logic [31:0]             o_rf_data,
  output logic [31:0]             o_pend_mask,
  output logic [$clog2(DEPTH):0]  o_fifo_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  typedef enum logic {S_NORM, S_DRAIN} state_t;

  state_t            r_state;
  logic [WW-1:0]     r_wait;
  logic [DW-1:0]     r_drain;
  logic              r_rf_we;
  logic [4:0]        r_rf_addr;
  logic [31:0]       r_rf_data;
  logic [31:0]       r_pend;

  logic [4:0]        r_rdst [DEPTH];
  logic [31:0]       r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  logic [CW-1:0]     w_cnt_nxt;
  logic [31:0]       w_cur_mask;
  logic [31:0]       w_push_mask;

  assign w_nonempty = (r_cnt != '0);
  assign o_lu_ready = rst & (r_cnt != CW'(DEPTH));
  assign w_push     = i_lu_valid & o_lu_ready;
  // Pops only ever see entries that were present at the start of the cycle.
  assign w_pop      = w_nonempty & ((r_state == S_DRAIN) | ~i_wb_we);
  assign w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_cur_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_cur_mask[r_rdst[i]] = 1'b1;
    end
  end

  assign w_push_mask = w_push ? (32'd1 << i_lu_rdst) : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rdst[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_rdst[r_wptr] <= i_lu_rdst;
        r_data[r_wptr] <= i_lu_data;
        r_vld[r_wptr]  <= 1'b1;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  // A popped entry stays in the mask one extra cycle so the bit covers the
  // registered write until the register file actually holds the value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pend <= '0;
    else      r_pend <= w_cur_mask | w_push_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_NORM;
      r_wait    <= '0;
      r_drain   <= '0;
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      r_rf_we <= 1'b0;
      case (r_state)
        S_NORM: begin
          if (i_wb_we) begin
            r_rf_we   <= 1'b1;
            r_rf_addr <= i_wb_rdst;
            r_rf_data <= i_wb_data;
            if (w_nonempty) begin
              if (r_wait == WW'(MAX_WAIT - 1)) begin
                r_state <= S_DRAIN;
                r_wait  <= '0;
              end else begin
                r_wait <= r_wait + 1'b1;
              end
            end else begin
              r_wait <= '0;
            end
          end else begin
            r_wait <= '0;
            if (w_nonempty) begin
              r_rf_we   <= 1'b1;
              r_rf_addr <= r_rdst[r_rptr];
              r_rf_data <= r_data[r_rptr];
            end
          end
        end
        S_DRAIN: begin
          if (w_nonempty) begin
            r_rf_we   <= 1'b1;
            r_rf_addr <= r_rdst[r_rptr];
            r_rf_data <= r_data[r_rptr];
          end
          if (!w_nonempty || (w_cnt_nxt == '0) || (r_drain == DW'(DRAIN_MAX - 1))) begin
            r_state <= S_NORM;
            r_drain <= '0;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        default: r_state <= S_NORM;
      endcase
    end
  end

  assign o_wb_stall  = (r_state == S_DRAIN);
  assign o_rf_we     = r_rf_we;
  assign o_rf_addr   = r_rf_addr;
  assign o_rf_data   = r_rf_data;
  assign o_pend_mask = r_pend;
  assign o_fifo_cnt  = r_cnt;

endmodule
